// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit pipeline: opcodes, field positions
// and the ID/EX control bundle consumed by decode, execute and hazard logic.
package isa_pkg;
  localparam int DW   = 16;
  localparam int NREG = 16;
  localparam int RW   = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_SLL = 4'h4, OP_SRL = 4'h5, OP_SRA = 4'h6, OP_ADDI = 4'h7,
    OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB,
    OP_B   = 4'hC, OP_J   = 4'hD, OP_NOP = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  localparam int OPC_LO  = 12;
  localparam int RD_LO   = 8;
  localparam int RS_LO   = 4;
  localparam int RT_LO   = 0;
  localparam int COND_LO = 9;

  typedef struct packed {
    logic       reg_we;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       halt;
    logic [2:0] cond;
  } ctrl_t;
endpackage

// File: rtl/reg_file_16x16.sv
// 16x16 register file: two async read ports with write-through bypass,
// one sync write port, R0 hardwired to zero.
module reg_file_16x16
  import isa_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] i_ra_addr,
  input  logic [RW-1:0] i_rb_addr,
  output logic [DW-1:0] o_ra_data,
  output logic [DW-1:0] o_rb_data,
  input  logic          i_we,
  input  logic [RW-1:0] i_wa,
  input  logic [DW-1:0] i_wd
);
  logic [NREG-1:0][DW-1:0] r_mem;
  logic                    w_wr;

  assign w_wr = i_we && (i_wa != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_mem        <= '0;
    else if (w_wr) r_mem[i_wa] <= i_wd;
  end

  // Bypass lets decode see a value being written back in the same cycle.
  always_comb begin
    o_ra_data = r_mem[i_ra_addr];
    o_rb_data = r_mem[i_rb_addr];
    if (w_wr && i_wa == i_ra_addr) o_ra_data = i_wd;
    if (w_wr && i_wa == i_rb_addr) o_rb_data = i_wd;
    if (i_ra_addr == '0) o_ra_data = '0;
    if (i_rb_addr == '0) o_rb_data = '0;
  end
endmodule

// File: rtl/id_ex_stage.sv
// Decode stage: decodes the IF_ID instruction, reads operands, detects
// load-use hazards and registers the result into the ID/EX pipeline register.
module id_ex_stage
  import isa_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [DW-1:0] instr,
  input  logic [DW-1:0] pc_incre,
  input  logic          flush,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          stall,
  output logic          halted,
  output logic          ex_valid,
  output logic [3:0]    ex_opcode,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic          ex_reg_we,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_branch,
  output logic          ex_jump,
  output logic          ex_halt,
  output logic [2:0]    ex_cond,
  output logic [DW-1:0] ex_pc_incre
);
  opcode_e       w_op;
  logic [RW-1:0] w_rd, w_ra, w_rb;
  logic [DW-1:0] w_ra_data, w_rb_data, w_imm;
  logic          w_use_a, w_use_b, w_load;
  ctrl_t         w_ctrl, r_ctrl;

  assign w_op    = opcode_e'(instr[OPC_LO +: 4]);
  assign w_rd    = instr[RD_LO +: RW];
  assign w_ra    = (w_op == OP_LLB || w_op == OP_LHB) ? w_rd : instr[RS_LO +: RW];
  assign w_rb    = (w_op == OP_SW) ? w_rd : instr[RT_LO +: RW];
  assign w_use_a = (w_op <= OP_LHB);
  assign w_use_b = (w_op <= OP_OR) || (w_op == OP_SW);

  reg_file_16x16 u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ra_addr (w_ra),
    .i_rb_addr (w_rb),
    .o_ra_data (w_ra_data),
    .o_rb_data (w_rb_data),
    .i_we      (wb_we),
    .i_wa      (wb_rd),
    .i_wd      (wb_data)
  );

  always_comb begin
    w_imm = '0;
    case (w_op)
      OP_SLL, OP_SRL, OP_SRA: w_imm = {12'h000, instr[3:0]};
      OP_ADDI, OP_LW, OP_SW:  w_imm = {{12{instr[3]}}, instr[3:0]};
      OP_LLB, OP_LHB:         w_imm = {8'h00, instr[7:0]};
      OP_B:                   w_imm = {{7{instr[8]}}, instr[8:0]};
      OP_J:                   w_imm = {{4{instr[11]}}, instr[11:0]};
      default:                w_imm = '0;
    endcase
  end

  always_comb begin
    w_ctrl           = '0;
    w_ctrl.reg_we    = ((w_op <= OP_LW) || w_op == OP_LLB || w_op == OP_LHB) && (w_rd != '0);
    w_ctrl.mem_read  = (w_op == OP_LW);
    w_ctrl.mem_write = (w_op == OP_SW);
    w_ctrl.branch    = (w_op == OP_B);
    w_ctrl.jump      = (w_op == OP_J);
    w_ctrl.halt      = (w_op == OP_HLT);
    w_ctrl.cond      = instr[COND_LO +: 3];
  end

  // Flush and halt suppress the stall so fetch is never frozen needlessly.
  assign stall = id_valid && ex_valid && r_ctrl.mem_read && (ex_rd != '0) &&
                 ((w_use_a && w_ra == ex_rd) || (w_use_b && w_rb == ex_rd)) &&
                 !flush && !halted;
  assign w_load = id_valid && !flush && !halted && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted      <= 1'b0;
      ex_valid    <= 1'b0;
      ex_opcode   <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_pc_incre <= '0;
      r_ctrl      <= '0;
    end else if (w_load) begin
      halted      <= halted | w_ctrl.halt;
      ex_valid    <= 1'b1;
      ex_opcode   <= w_op;
      ex_rs       <= w_ra;
      ex_rt       <= w_rb;
      ex_rd       <= w_rd;
      ex_rs_data  <= w_ra_data;
      ex_rt_data  <= w_rb_data;
      ex_imm      <= w_imm;
      ex_pc_incre <= pc_incre;
      r_ctrl      <= w_ctrl;
    end else begin
      ex_valid    <= 1'b0;
      ex_opcode   <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_pc_incre <= '0;
      r_ctrl      <= '0;
    end
  end

  assign ex_reg_we    = r_ctrl.reg_we;
  assign ex_mem_read  = r_ctrl.mem_read;
  assign ex_mem_write = r_ctrl.mem_write;
  assign ex_branch    = r_ctrl.branch;
  assign ex_jump      = r_ctrl.jump;
  assign ex_halt      = r_ctrl.halt;
  assign ex_cond      = r_ctrl.cond;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, bypass, load-use, flush, halt, reset.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n, id_valid, flush, wb_we;
  logic [15:0] instr, pc_incre, wb_data;
  logic [3:0]  wb_rd;
  logic        stall, halted, ex_valid;
  logic [3:0]  ex_opcode, ex_rs, ex_rt, ex_rd;
  logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_incre;
  logic        ex_reg_we, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_halt;
  logic [2:0]  ex_cond;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .instr(instr),
    .pc_incre(pc_incre), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .stall(stall), .halted(halted), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_halt(ex_halt),
    .ex_cond(ex_cond), .ex_pc_incre(ex_pc_incre)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic fl);
    id_valid = v; instr = ins; flush = fl; pc_incre = pc_incre + 16'd1;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; instr = 16'hE000; pc_incre = 16'h0100;
    flush = 1'b0; wb_we = 1'b0; wb_rd = 4'd0; wb_data = 16'h0000;
    #12;
    chk("rst_valid", ex_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_imm", ex_imm, 0);
    rst_n = 1'b1;

    // ADDI R1,R0,-3
    drive(1, 16'h710D, 0);
    step();
    chk("addi_valid", ex_valid, 1);
    chk("addi_imm", ex_imm, 16'hFFFD);
    chk("addi_we", ex_reg_we, 1);
    chk("addi_rd", ex_rd, 1);
    chk("addi_rsdata", ex_rs_data, 0);
    chk("addi_pc", ex_pc_incre, 16'h0101);

    // ADD R3,R2,R2 with same-cycle write-back of R2
    drive(1, 16'h0322, 0);
    wb_we = 1; wb_rd = 4'd2; wb_data = 16'h1234;
    step();
    chk("byp_rs", ex_rs_data, 16'h1234);
    chk("byp_rt", ex_rt_data, 16'h1234);
    chk("byp_rd", ex_rd, 3);

    // Attempted write to R0 while reading R0 and R2
    drive(1, 16'h0602, 0);
    wb_we = 1; wb_rd = 4'd0; wb_data = 16'hFFFF;
    step();
    chk("r0_byp", ex_rs_data, 0);
    chk("r2_stored", ex_rt_data, 16'h1234);
    wb_we = 0;
    step();
    chk("r0_later", ex_rs_data, 0);

    // LW R4 then dependent ADD R5,R4,R1
    drive(1, 16'h8400, 0);
    step();
    chk("lw_mread", ex_mem_read, 1);
    chk("lw_rd", ex_rd, 4);
    drive(1, 16'h0541, 0);
    #1 chk("lu_stall", stall, 1);
    step();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_stall_clr", stall, 0);
    step();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rs", ex_rs, 4);
    chk("lu_add_rt", ex_rt, 1);

    // LW then independent SUB
    drive(1, 16'h8400, 0);
    step();
    drive(1, 16'h1512, 0);
    #1 chk("nodep_stall", stall, 0);
    step();
    chk("sub_valid", ex_valid, 1);
    chk("sub_op", ex_opcode, 1);

    // LW then dependent ADD under flush: flush wins
    drive(1, 16'h8400, 0);
    step();
    drive(1, 16'h0541, 1);
    #1 chk("flush_nostall", stall, 0);
    step();
    chk("flush_bubble", ex_valid, 0);
    drive(1, 16'hC3FF, 1);
    step();
    chk("flushb_valid", ex_valid, 0);
    chk("flushb_branch", ex_branch, 0);
    drive(1, 16'hC3FF, 0);
    step();
    chk("b_valid", ex_valid, 1);
    chk("b_branch", ex_branch, 1);
    chk("b_cond", ex_cond, 3'd1);
    chk("b_imm", ex_imm, 16'hFFFF);
    chk("b_we", ex_reg_we, 0);

    drive(1, 16'hD800, 0);
    step();
    chk("j_jump", ex_jump, 1);
    chk("j_imm", ex_imm, 16'hF800);

    // LLB R7,0xC5: port A reads rd
    drive(1, 16'hA7C5, 0);
    step();
    chk("llb_rs", ex_rs, 7);
    chk("llb_imm", ex_imm, 16'h00C5);
    chk("llb_we", ex_reg_we, 1);

    // SW R10,[R2+1]: port B reads [11:8]
    drive(1, 16'h9A21, 0);
    step();
    chk("sw_rt", ex_rt, 4'hA);
    chk("sw_rsdata", ex_rs_data, 16'h1234);
    chk("sw_imm", ex_imm, 16'h0001);
    chk("sw_mwrite", ex_mem_write, 1);
    chk("sw_we", ex_reg_we, 0);

    drive(1, 16'h4123, 0);
    step();
    chk("sll_imm", ex_imm, 16'h0003);

    // Idle cycle
    drive(0, 16'h0322, 0);
    step();
    chk("idle_bubble", ex_valid, 0);

    // HLT, then later decodes are bubbles
    drive(1, 16'hF000, 0);
    step();
    chk("hlt_valid", ex_valid, 1);
    chk("hlt_halt", ex_halt, 1);
    chk("hlt_halted", halted, 1);
    drive(1, 16'h0322, 0);
    step();
    chk("halt_bubble", ex_valid, 0);
    chk("halt_sticky", halted, 1);
    chk("halt_nostall", stall, 0);

    // Asynchronous mid-cycle reset
    #3 rst_n = 1'b0;
    #1;
    chk("arst_halted", halted, 0);
    chk("arst_halt", ex_halt, 0);
    #1 rst_n = 1'b1;
    drive(1, 16'h0322, 0);
    step();
    chk("post_rst_valid", ex_valid, 1);
    chk("post_rst_r2", ex_rs_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage directly downstream of the fetch stage (IF_ID).
- Consumes the fetched instr and incremented PC, decodes the 16-bit instruction, and reads a 16x16 register file with write-back bypass.
- Detects load-use hazards and stalls fetch; handles flush and halt.
- Registers everything into the ID/EX pipeline register feeding execute.

Parameters:
- NREG, 16, number of architectural registers; R0 reads as zero.
- DW, 16, datapath and instruction width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  instr/pc_incre from IF_ID are valid this cycle.
- instr  in  16  fetched instruction.
- pc_incre  in  16  PC+1 of instr.
- flush  in  1  taken branch/jump resolved downstream; current decode is squashed.
- wb_we  in  1  write-back enable.
- wb_rd  in  4  write-back register.
- wb_data  in  16  write-back data.
- stall  out  1  combinational; fetch must hold PC and IF_ID (drives IF hlt).
- halted  out  1  sticky; HLT has entered ID/EX.
- ex_valid  out  1  ID/EX holds a real instruction (0 = bubble).
- ex_opcode  out  4  instr[15:12].
- ex_rs, ex_rt, ex_rd  out  4 each  register specifiers, for forwarding.
- ex_rs_data, ex_rt_data  out  16 each  register operands.
- ex_imm  out  16  extended immediate.
- ex_reg_we, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_halt  out  1 each  control bits.
- ex_cond  out  3  branch condition, instr[11:9].
- ex_pc_incre  out  16  pipelined pc_incre.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SRA, 7 ADDI, 8 LW, 9 SW, A LLB, B LHB, C B, D J, E NOP, F HLT.
- Fields: rd=[11:8], rs=[7:4], rt=[3:0].
- Read port A address:
  - rd for LLB/LHB;
  - rs for all others.
- Read port B address:
  - [11:8] for SW (store data);
  - rt for all others.
- Source use:
  - Port A is used by 0-B.
  - Port B is used by 0-3 and 9.
- ex_rs/ex_rt carry the actual read addresses.
- Immediate:
  - 4-6: zero-extend [3:0].
  - 7-9: sign-extend [3:0].
  - A/B: zero-extend [7:0].
  - C: sign-extend [8:0].
  - D: sign-extend [11:0].
  - Others: 0.
- Control:
  - reg_we for 0-8, A, B, with rd != 0.
  - mem_read for 8 only.
  - mem_write for 9 only.
  - branch for C.
  - jump for D.
  - halt for F.
  - E is valid with all controls 0.
- Register file:
  - Writes at posedge when wb_we and wb_rd != 0; R0 is never written.
  - Read bypass: same-cycle wb write to the read address returns wb_data.
  - R0 always reads 0.
- Load-use: stall=1 when all of the following hold:
  - id_valid, ex_valid, ex_mem_read, ex_rd != 0;
  - a used source address == ex_rd;
  - flush=0, halted=0.
- Latency: 1 cycle from id_valid decode to ex_* outputs.
- Next-state priority (high to low):
  1. reset: all ex_* = 0, halted = 0, all registers = 0.
  2. flush: bubble (ex_valid=0, all controls 0, data don't-care but driven 0).
  3. halted: bubble.
  4. stall: bubble; decode is retried next cycle because IF holds.
  5. !id_valid: bubble.
  6. otherwise: load decoded instruction.
- halted sets on the edge that loads an HLT with ex_halt=1. It stays set until reset; later decodes become bubbles and stall=0.
- flush and stall together: flush wins, stall=0.
- wb writes continue while halted, stalled or flushed.
- Reset asserted mid-operation clears state immediately, independent of clk. Release takes effect on the next posedge.

Decomposition:
- Shared package isa_pkg holds:
  - opcode constants (OP_ADD..OP_HLT);
  - field bit positions;
  - the ID/EX control-bundle struct (reg_we, mem_read, mem_write, branch, jump, halt, cond).
- The execute stage and hazard logic reuse this package.
- One sub-module, reg_file_16x16: 2 async read ports, 1 sync write port, internal bypass, R0 = 0, async reset clear.

Test Plan:
- Reset then ADDI R1,R0,-3 (0x710D) with id_valid=1 -> next edge: ex_valid=1, ex_imm=0xFFFD, ex_reg_we=1, ex_rd=1, ex_rs_data=0.
- wb_we=1, wb_rd=2, wb_data=0x1234 while decoding ADD R3,R2,R2 (0x0322) -> ex_rs_data=ex_rt_data=0x1234 (bypass); then wb_rd=0 write of 0xFFFF -> a later read of R0 returns 0.
- LW R4,[R0+0] (0x8400) followed by ADD R5,R4,R1 (0x0541):
  - first cycle: stall=1, bubble in ID/EX;
  - second cycle: stall=0, ADD loaded.
- Same LW followed by SUB R5,R1,R2 (0x1512) -> stall=0.
- Decode B with instr=0xC3FF and flush=1 on the same cycle -> ex_valid=0, no stall; next instruction decodes normally.
- HLT (0xF000) -> ex_halt=1 and halted=1 after the edge; following ADD instructions produce ex_valid=0; rst_n pulse low mid-cycle clears halted and ex_* asynchronously.
